// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core's MEM-stage data port and a slow data memory.
// Stores queue in a FIFO and drain over req/ack; loads forward from the youngest matching pending store.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [AW-1:0] memaddr,
    input  logic [DW-1:0] memwritedata,
    output logic [DW-1:0] memreaddata,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wreq,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW-3:0]   r_addr [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_wreq;
    logic            w_hit;
    logic [DW-1:0]   w_fwd_data;
    logic [1:0]      w_unused_lsb;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    // A store presented while full is refused even if the head retires this cycle.
    assign w_push       = memwrite & ~w_full;
    assign w_unused_lsb = memaddr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // count is at least 1 while in REQ, so the last entry retiring is count==1
                if (mem_wack && (r_count == CW'(1))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wreq = (r_state == S_REQ);
        w_pop  = w_wreq & mem_wack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= memaddr[AW-1:2];
            r_data[r_tail] <= memwritedata;
        end
    end

    // Walk from head toward tail; later matches overwrite earlier ones, leaving the youngest.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_addr[r_head + PW'(i)] == memaddr[AW-1:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[r_head + PW'(i)];
            end
        end
    end

    assign memreaddata = (memread && w_hit) ? w_fwd_data : mem_rdata;
    assign mem_raddr   = {memaddr[AW-1:2], 2'b00};
    assign stall       = memwrite & w_full;
    assign empty       = w_empty;
    assign mem_wreq    = w_wreq;
    assign mem_waddr   = {r_addr[r_head], 2'b00};
    assign mem_wdata   = r_data[r_head];

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the pipelined core's MEM-stage data port and a slower data memory.
- Stores are accepted in one cycle and held in a DEPTH-entry FIFO. A drain state machine retires them to memory over a req/ack handshake.
- Loads read memory combinationally. A load hits in the buffer if it matches a pending store, and the youngest matching entry is forwarded.
- `stall` tells the core's hazard logic to freeze the pipeline when the buffer is full.

Parameters:
- DEPTH, 4, number of store entries (power of two, ≥2).
- AW, 32, address width.
- DW, 32, data width (word stores only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  MEM-stage store request.
- memread  in  1  MEM-stage load request.
- memaddr  in  AW  byte address from the ALU result.
- memwritedata  in  DW  store data.
- memreaddata  out  DW  load data to the core (combinational).
- stall  out  1  buffer full; the core must hold the MEM-stage store.
- empty  out  1  no pending stores.
- mem_raddr  out  AW  memory read address, equal to memaddr with [1:0] forced to 00.
- mem_rdata  in  DW  memory read data (combinational, same cycle).
- mem_wreq  out  1  memory write request (registered).
- mem_waddr  out  AW  write address of the head entry.
- mem_wdata  out  DW  write data of the head entry.
- mem_wack  in  1  memory accepts the write this cycle.

Behaviour:
- Storage:
  - DEPTH entries of {addr[AW-1:2], data}.
  - head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Reset (reset=0, asynchronous):
  - head, tail and count go to 0; all pending entries are discarded.
  - FSM goes to IDLE; mem_wreq goes to 0 immediately.
  - stall=0, empty=1. Entry contents do not need to be cleared.
- Enqueue:
  - Condition: memwrite=1 and full=0 at a rising edge.
  - Writes {memaddr[AW-1:2], memwritedata} at tail and increments tail.
  - memaddr[1:0] is ignored.
- Stall:
  - stall = memwrite & full, combinational on the registered count.
  - A store arriving while full is not accepted, even if a pop happens in the same cycle (conservative). The core re-presents it next cycle.
- Count on simultaneous enqueue and pop: count is unchanged; head and tail both advance.
- Drain FSM, states IDLE and REQ:
  - IDLE: if count>0 at the edge, go to REQ with mem_wreq=1.
  - REQ: mem_wreq=1, with mem_waddr={head addr,2'b00} and mem_wdata=head data held stable until ack.
  - REQ with mem_wack=1: pop the head (head+1, count-1). If count-1>0, stay in REQ; the next entry is presented on the following cycle. Otherwise go to IDLE with mem_wreq=0.
  - mem_wack is ignored in IDLE.
  - Consequence: back-to-back acks give one retire per cycle.
- Load forwarding:
  - When memread=1, compare memaddr[AW-1:2] against every valid entry (the slots between head and tail).
  - If one or more match, memreaddata = data of the youngest match (closest to tail).
  - If none match, memreaddata = mem_rdata.
  - The entry being acked in the current cycle still counts as valid for forwarding in that cycle.
  - When memread=0, memreaddata = mem_rdata.
- Ordering: stores retire strictly in program order. Loads never bypass a matching pending store.
- Unsupported: memwrite and memread in the same cycle is illegal from the core; the store takes effect and the load result is unspecified.
- Latency:
  - Store accept: 0 extra cycles when not full.
  - First mem_wreq: 1 cycle after the first enqueue into an empty buffer.
  - Load: combinational.

Test Plan:
- Reset release then idle: mem_wreq=0, empty=1, stall=0. Load of 0x40 with mem_rdata=0xAAAA_0000 -> memreaddata=0xAAAA_0000.
- Single store 0x100←0x1234 with mem_wack held at 0 for 3 cycles, then 1:
  - mem_wreq rises 1 cycle after the enqueue, with addr 0x100 and data 0x1234 stable throughout.
  - Pops on the ack; empty=1 the next cycle.
- Forwarding, mem_wack=0:
  - Stores 0x200←0x11 then 0x200←0x22; load 0x202 -> memreaddata=0x22, not mem_rdata.
  - Load 0x204 -> mem_rdata.
- Full: 4 stores with mem_wack=0 -> count=4; 5th store -> stall=1 and is not enqueued. Pulse one ack -> stall=0 next cycle; 5th store accepted; retire order 1,2,3,4,5.
- mem_wack tied to 1 with 3 queued stores -> three consecutive retire cycles, then mem_wreq=0, empty=1.
- Assert reset while in REQ with 2 entries pending -> mem_wreq=0 asynchronously. After release: empty=1 and no writes issued.
